data_memory_ctrl: RTL and testbench

//  Handshaked data memory for the MEM stage: valid/ready request, valid/ready response,

---
 rtl/dmem_pkg.sv | 29 ++
 rtl/mem_align_unit.sv | 60 ++++++
 rtl/data_memory_ctrl.sv | 115 +++++++++++
 tb/tb_data_memory_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the MEM-stage data memory controller.
package dmem_pkg;

  localparam int XLEN  = 32;
  localparam int BYTES = XLEN / 8;
  localparam int OFF_W = $clog2(BYTES);

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LD  = 3'b011,
    LBU = 3'b100,
    LHU = 3'b101,
    LWU = 3'b110
  } mem_op_e;

  localparam mem_op_e SB = LB;
  localparam mem_op_e SH = LH;
  localparam mem_op_e SW = LW;
  localparam mem_op_e SD = LD;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/mem_align_unit.sv
// Lane steering for loads/stores: byte enables, store shift,
// load extraction with sign/zero extension, and size/legality faults.
module mem_align_unit
  import dmem_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  localparam int NB         = DATA_WIDTH / 8,
  localparam int OW         = $clog2(NB)
) (
  input  logic                  we,
  input  logic [2:0]            funct3,
  input  logic [OW-1:0]         offset,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] raw,
  output logic [NB-1:0]         byte_en,
  output logic [DATA_WIDTH-1:0] wdata_sh,
  output logic                  fault,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [3:0]            nbytes;
  logic [2:0]            off3;
  logic                  illegal;
  logic                  misal;
  logic                  msb;
  logic [DATA_WIDTH-1:0] shifted;

  always_comb begin
    nbytes  = 4'd1 << funct3[1:0];
    off3    = 3'(offset);
    illegal = (funct3 == 3'b111)
            | (we & funct3[2])
            | ((DATA_WIDTH == 32) & (funct3[1:0] == 2'b11))
            | ((DATA_WIDTH == 32) & (funct3 == 3'b110));
    misal   = (off3 & 3'(nbytes - 4'd1)) != 3'd0;
    fault   = illegal | misal;

    byte_en  = '0;
    if (!fault)
      byte_en = NB'((16'd1 << nbytes) - 16'd1) << offset;
    wdata_sh = wdata << {offset, 3'b000};

    shifted = raw >> {offset, 3'b000};
    unique case (1'b1)
      funct3[1:0] == 2'b00: msb = shifted[7];
      funct3[1:0] == 2'b01: msb = shifted[15];
      funct3[1:0] == 2'b10: msb = shifted[31];
      funct3[1:0] == 2'b11: msb = shifted[DATA_WIDTH-1];
      default:              msb = 1'b0;
    endcase

    rdata = shifted;
    for (int i = 8; i < DATA_WIDTH; i++)
      if (i >= 8 * int'(nbytes))
        rdata[i] = ~funct3[2] & msb;
    if (fault)
      rdata = '0;
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Handshaked MEM-stage data memory: one access in flight,
// LATENCY-cycle commit, RV load/store sizes with fault reporting.
module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024,
  parameter int LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int OW    = $clog2(NB);
  localparam int IDX_W = ADDR_WIDTH - OW;
  localparam int IW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  // Zero at time 0 only; reset deliberately leaves contents alone.
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH] = '{default: '0};

  dmem_state_e           state;
  logic [CW-1:0]         cnt;
  logic                  r_we;
  logic [2:0]            r_f3;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;

  logic [IDX_W-1:0]      idx;
  logic [IW-1:0]         widx;
  logic                  oor;
  logic                  err;
  logic                  commit;
  logic [NB-1:0]         byte_en;
  logic [DATA_WIDTH-1:0] wdata_sh;
  logic [DATA_WIDTH-1:0] ext;
  logic                  fault;

  assign idx       = r_addr[ADDR_WIDTH-1:OW];
  assign widx      = idx[IW-1:0];
  assign oor       = idx >= IDX_W'(MEM_DEPTH);
  assign err       = fault | oor;
  assign commit    = (state == S_WAIT) && (cnt == '0);
  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);

  mem_align_unit #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_align (
    .we      (r_we),
    .funct3  (r_f3),
    .offset  (r_addr[OW-1:0]),
    .wdata   (r_wdata),
    .raw     (mem[widx]),
    .byte_en (byte_en),
    .wdata_sh(wdata_sh),
    .fault   (fault),
    .rdata   (ext)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      r_we      <= 1'b0;
      r_f3      <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (req_valid) begin
          r_we    <= req_we;
          r_f3    <= req_funct3;
          r_addr  <= req_addr;
          r_wdata <= req_wdata;
          cnt     <= CW'(LATENCY - 1);
          state   <= S_WAIT;
        end
        S_WAIT: if (cnt != '0) begin
          cnt <= cnt - 1'b1;
        end else begin
          rsp_rdata <= (err || r_we) ? '0 : ext;
          rsp_err   <= err;
          state     <= S_RESP;
        end
        S_RESP: if (rsp_ready)
          state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // A reset mid-WAIT forces IDLE asynchronously, so no late write.
  always_ff @(posedge clk) begin
    if (commit && r_we && !err)
      for (int b = 0; b < NB; b++)
        if (byte_en[b])
          mem[widx][8*b +: 8] <= wdata_sh[8*b +: 8];
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: 32b/LATENCY=3 and 64b/LATENCY=4 instances
// against a byte-addressed reference memory with per-cycle output checks.
module tb_data_memory_ctrl;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst        [2];
  logic        req_valid  [2];
  logic        req_we     [2];
  logic        rsp_ready  [2];
  logic [2:0]  req_funct3 [2];
  logic [31:0] req_addr   [2];
  logic [63:0] req_wdata  [2];

  logic        rr0, rr1, rv0, rv1, er0, er1;
  logic [31:0] rd0;
  logic [63:0] rd1;

  int checks = 0;
  int errors = 0;

  data_memory_ctrl #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(DEPTH), .LATENCY(3)
  ) dut0 (
    .clk(clk), .rst(rst[0]),
    .req_valid(req_valid[0]), .req_ready(rr0),
    .req_we(req_we[0]), .req_funct3(req_funct3[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0][31:0]),
    .rsp_valid(rv0), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rd0), .rsp_err(er0)
  );

  data_memory_ctrl #(
    .DATA_WIDTH(64), .ADDR_WIDTH(32), .MEM_DEPTH(DEPTH), .LATENCY(4)
  ) dut1 (
    .clk(clk), .rst(rst[1]),
    .req_valid(req_valid[1]), .req_ready(rr1),
    .req_we(req_we[1]), .req_funct3(req_funct3[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rv1), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rd1), .rsp_err(er1)
  );

  function automatic int wb(int d);
    return (d == 0) ? 4 : 8;
  endfunction

  function automatic int lat(int d);
    return (d == 0) ? 3 : 4;
  endfunction

  function automatic logic o_rr(int d);
    return (d == 0) ? rr0 : rr1;
  endfunction

  function automatic logic o_rv(int d);
    return (d == 0) ? rv0 : rv1;
  endfunction

  function automatic logic o_er(int d);
    return (d == 0) ? er0 : er1;
  endfunction

  function automatic logic [63:0] o_rd(int d);
    return (d == 0) ? {32'h0, rd0} : rd1;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference memory: plain byte-addressed storage, zero by default.
  logic [7:0] mem0 [int unsigned];
  logic [7:0] mem1 [int unsigned];

  function automatic logic [7:0] mrd(int d, int unsigned a);
    if (d == 0) return mem0.exists(a) ? mem0[a] : 8'h00;
    return mem1.exists(a) ? mem1[a] : 8'h00;
  endfunction

  task automatic mwr(int d, int unsigned a, logic [7:0] v);
    if (d == 0) mem0[a] = v;
    else        mem1[a] = v;
  endtask

  task automatic predict(input int d, input logic we, input logic [2:0] f,
                         input logic [31:0] a, output logic err,
                         output logic [63:0] rd);
    int  n;
    bit  ill;
    n   = 1 << f[1:0];
    ill = (f == 3'b111) || (we && f[2]) ||
          (wb(d) == 4 && (f == 3'b011 || f == 3'b110));
    err = ill || (a % n != 0) || (a / wb(d) >= DEPTH);
    rd  = '0;
    if (!err && !we) begin
      for (int i = 0; i < n; i++)
        rd[8*i +: 8] = mrd(d, a + i);
      if (!f[2] && rd[8*n-1])
        for (int j = 8 * n; j < 8 * wb(d); j++)
          rd[j] = 1'b1;
    end
  endtask

  int          busy [2];
  int          age  [2];
  logic [63:0] e_rd [2];
  logic        e_err[2];
  logic        p_we [2];
  logic [31:0] p_a  [2];
  logic [63:0] p_wd [2];
  int          p_n  [2];

  initial begin
    for (int d = 0; d < 2; d++) begin
      busy[d] = 0; age[d] = 0; e_rd[d] = '0; e_err[d] = 1'b0;
    end
  end

  // Model: accept when idle, commit LATENCY edges later, retire on rsp_ready.
  initial forever begin
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (!rst[d]) begin
        busy[d] = 0;
      end else if (busy[d] == 0) begin
        if (req_valid[d]) begin
          predict(d, req_we[d], req_funct3[d], req_addr[d], e_err[d], e_rd[d]);
          p_we[d] = req_we[d];
          p_a[d]  = req_addr[d];
          p_wd[d] = req_wdata[d];
          p_n[d]  = 1 << req_funct3[d][1:0];
          busy[d] = 1;
          age[d]  = 0;
        end
      end else if (age[d] < lat(d)) begin
        age[d]++;
        if (age[d] == lat(d) && p_we[d] && !e_err[d])
          for (int i = 0; i < p_n[d]; i++)
            mwr(d, p_a[d] + i, p_wd[d][8*i +: 8]);
      end else if (rsp_ready[d]) begin
        busy[d] = 0;
      end
    end
  end

  initial forever begin
    @(negedge rst[0] or negedge rst[1]);
    for (int d = 0; d < 2; d++)
      if (!rst[d]) busy[d] = 0;
  end

  initial forever begin
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      logic ev;
      ev = (busy[d] != 0) && (age[d] == lat(d));
      chk($sformatf("req_ready dut%0d", d), 64'(o_rr(d)), 64'(busy[d] == 0));
      chk($sformatf("rsp_valid dut%0d", d), 64'(o_rv(d)), 64'(ev));
      if (ev) begin
        chk($sformatf("rsp_rdata dut%0d", d), o_rd(d),
            (d == 0) ? {32'h0, e_rd[0][31:0]} : e_rd[1]);
        chk($sformatf("rsp_err dut%0d", d), 64'(o_er(d)), 64'(e_err[d]));
      end
    end
  end

  task automatic send(input int d, input logic we, input logic [2:0] f,
                      input logic [31:0] a, input logic [63:0] wd,
                      input int hold, output bit ok);
    int n;
    ok = 1'b0;
    @(posedge clk); #1;
    req_valid[d]  = 1'b1;
    req_we[d]     = we;
    req_funct3[d] = f;
    req_addr[d]   = a;
    req_wdata[d]  = wd;
    rsp_ready[d]  = (hold == 0);
    n = 0;
    do begin @(negedge clk); n++; end while (!o_rr(d) && n < 20);
    if (!o_rr(d)) begin
      checks++; errors++;
      $display("FAIL accept_timeout dut%0d: req_ready got 0, required 1", d);
      req_valid[d] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid[d]  = 1'b0;
    req_we[d]     = 1'($urandom);
    req_funct3[d] = 3'($urandom);
    req_addr[d]   = $urandom;
    req_wdata[d]  = {$urandom, $urandom};
    ok = 1'b1;
  endtask

  task automatic recv(input int d, input int hold, output logic [63:0] rd,
                      output logic er, output int lt);
    int n;
    rd = '0; er = 1'b0; lt = -1;
    n = 0;
    do begin @(negedge clk); n++; end while (!o_rv(d) && n < 30);
    if (!o_rv(d)) begin
      checks++; errors++;
      $display("FAIL rsp_timeout dut%0d: rsp_valid got 0, required 1", d);
      return;
    end
    lt = n - 1;
    rd = o_rd(d);
    er = o_er(d);
    repeat (hold) @(negedge clk);
    rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[d] = 1'b0;
  endtask

  task automatic xact(input int d, input logic we, input logic [2:0] f,
                      input logic [31:0] a, input logic [63:0] wd,
                      input int hold, output logic [63:0] rd,
                      output logic er, output int lt);
    bit ok;
    rd = '0; er = 1'b0; lt = -1;
    send(d, we, f, a, wd, hold, ok);
    if (ok) recv(d, hold, rd, er, lt);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [63:0] rd;
  logic        er;
  int          lt;
  bit          ok;
  logic [2:0]  f;
  logic [31:0] a;
  logic        we;
  int          hold;

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0;
      rsp_ready[d] = 1'b0; req_funct3[d] = '0; req_addr[d] = '0;
      req_wdata[d] = '0;
    end
    #2;
    rst[0] = 1'b0; rst[1] = 1'b0;
    #1;
    chk("reset req_ready", 64'(rr0), 64'd1);
    chk("reset rsp_valid", 64'(rv0), 64'd0);
    chk("reset rsp_rdata", 64'(rd0), 64'd0);
    chk("reset rsp_err",   64'(er0), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst[0] = 1'b1; rst[1] = 1'b1;

    // 32b sign/zero extension of a stored word
    xact(0, 1, 3'b010, 32'h10, 64'h8000_00F1, 0, rd, er, lt);
    xact(0, 0, 3'b000, 32'h10, 64'h0, 0, rd, er, lt);
    chk("LB ext", rd, 64'hFFFF_FFF1);
    xact(0, 0, 3'b100, 32'h10, 64'h0, 0, rd, er, lt);
    chk("LBU ext", rd, 64'hF1);
    xact(0, 0, 3'b001, 32'h10, 64'h0, 0, rd, er, lt);
    chk("LH ext", rd, 64'h0000_00F1);
    xact(0, 0, 3'b101, 32'h10, 64'h0, 0, rd, er, lt);
    chk("LHU ext", rd, 64'hF1);

    // Byte store merges into one lane only
    xact(0, 1, 3'b010, 32'h10, 64'h1122_3344, 0, rd, er, lt);
    xact(0, 1, 3'b000, 32'h13, 64'hFFFF_FFAB, 0, rd, er, lt);
    xact(0, 0, 3'b010, 32'h10, 64'h0, 0, rd, er, lt);
    chk("SB merge", rd, 64'hAB22_3344);
    xact(0, 0, 3'b010, 32'h14, 64'h0, 0, rd, er, lt);
    chk("neighbour word", rd, 64'h0);

    // Latency and back-pressure hold
    xact(0, 0, 3'b010, 32'h10, 64'h0, 5, rd, er, lt);
    chk("latency3", 64'(lt), 64'd3);
    chk("held rdata", rd, 64'hAB22_3344);

    // Faults
    xact(0, 0, 3'b010, 32'h12, 64'h0, 0, rd, er, lt);
    chk("LW misalign err", 64'(er), 64'd1);
    chk("LW misalign rdata", rd, 64'h0);
    xact(0, 1, 3'b001, 32'h11, 64'hFFFF, 0, rd, er, lt);
    chk("SH misalign err", 64'(er), 64'd1);
    xact(0, 0, 3'b011, 32'h10, 64'h0, 0, rd, er, lt);
    chk("LD on 32b err", 64'(er), 64'd1);
    xact(0, 0, 3'b010, 32'(4 * DEPTH), 64'h0, 0, rd, er, lt);
    chk("out of range err", 64'(er), 64'd1);
    chk("out of range rdata", rd, 64'h0);
    xact(0, 0, 3'b010, 32'h10, 64'h0, 0, rd, er, lt);
    chk("mem after faults", rd, 64'hAB22_3344);

    // 64b word ops
    xact(1, 1, 3'b011, 32'h8, 64'h8877_6655_4433_2211, 0, rd, er, lt);
    xact(1, 0, 3'b110, 32'hC, 64'h0, 0, rd, er, lt);
    chk("LWU 64", rd, 64'h8877_6655);
    chk("latency4", 64'(lt), 64'd4);
    xact(1, 0, 3'b010, 32'hC, 64'h0, 0, rd, er, lt);
    chk("LW 64", rd, 64'hFFFF_FFFF_8877_6655);

    // Reset mid-WAIT discards the pending store
    xact(1, 1, 3'b010, 32'h20, 64'h1234_5678, 0, rd, er, lt);
    send(1, 1, 3'b010, 32'h20, 64'hDEAD_BEEF, 0, ok);
    @(posedge clk);
    @(posedge clk); #1;
    rst[1] = 1'b0;
    @(negedge clk);
    chk("rst mid-wait rsp_valid", 64'(rv1), 64'd0);
    chk("rst mid-wait req_ready", 64'(rr1), 64'd1);
    @(posedge clk); #1;
    rst[1] = 1'b1;
    repeat (6) @(posedge clk);
    xact(1, 0, 3'b010, 32'h20, 64'h0, 0, rd, er, lt);
    chk("discarded store", rd, 64'h1234_5678);

    // Random traffic, checked cycle-by-cycle against the model
    for (int i = 0; i < 250; i++) begin
      for (int d = 0; d < 2; d++) begin
        we   = 1'($urandom);
        f    = 3'($urandom);
        a    = $urandom_range(0, DEPTH * wb(d) + 15);
        if ($urandom_range(0, 3) != 0)
          a = a & ~(32'(1 << f[1:0]) - 32'd1);
        hold = $urandom_range(0, 2);
        xact(d, we, f, a, {$urandom, $urandom}, hold, rd, er, lt);
      end
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
